lcd_ctrl_param: RTL and testbench



---
 rtl/lcd_pkg.sv | 20 ++
 rtl/lcd_ctrl_param_if.sv | 15 +
 rtl/lcd_window_alu.sv | 40 ++++
 rtl/lcd_ctrl_param.sv | 142 ++++++++++++++
 tb/tb_lcd_ctrl_param.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: opcodes, FSM encoding and pixel addressing shared by the LCD controller
package lcd_pkg;
    typedef enum logic [1:0] {S_LOAD, S_IDLE, S_EXEC, S_WRITE} state_t;
    localparam logic [3:0] CMD_WRITE  = 4'd0;
    localparam logic [3:0] CMD_UP     = 4'd1;
    localparam logic [3:0] CMD_DOWN   = 4'd2;
    localparam logic [3:0] CMD_LEFT   = 4'd3;
    localparam logic [3:0] CMD_RIGHT  = 4'd4;
    localparam logic [3:0] CMD_AVG    = 4'd5;
    localparam logic [3:0] CMD_MIRX   = 4'd6;
    localparam logic [3:0] CMD_MIRY   = 4'd7;
    localparam logic [3:0] CMD_MAX    = 4'd8;
    localparam logic [3:0] CMD_MIN    = 4'd9;
    localparam logic [3:0] CMD_ROTCW  = 4'd10;
    localparam logic [3:0] CMD_ROTCCW = 4'd11;
    localparam logic [3:0] CMD_HOME   = 4'd12;
    function automatic int pix_addr(input int y, input int x, input int xw);
        return (y << xw) | x;
    endfunction
endpackage

// File: rtl/lcd_ctrl_param_if.sv
// lcd_ctrl_param_if: command strobe plus IROM/IRB bus of the LCD controller
interface lcd_ctrl_param_if #(parameter int DW = 8, parameter int AW = 6);
    logic [DW-1:0] IROM_Q;
    logic [3:0]    cmd;
    logic          cmd_valid;
    logic          IROM_EN;
    logic [AW-1:0] IROM_A;
    logic          IRB_RW;
    logic [DW-1:0] IRB_D;
    logic [AW-1:0] IRB_A;
    logic          busy;
    logic          done;
    modport master (output IROM_Q, cmd, cmd_valid, input IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done);
    modport slave  (input IROM_Q, cmd, cmd_valid, output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done);
endinterface

// File: rtl/lcd_window_alu.sv
// lcd_window_alu: combinational rewrite of the 2x2 cursor window for the pixel-editing opcodes
module lcd_window_alu import lcd_pkg::*; #(
    parameter int DW = 8
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] p0,
    input  logic [DW-1:0] p1,
    input  logic [DW-1:0] p2,
    input  logic [DW-1:0] p3,
    output logic [DW-1:0] n0,
    output logic [DW-1:0] n1,
    output logic [DW-1:0] n2,
    output logic [DW-1:0] n3,
    output logic          we
);
    logic [DW+1:0] sum;
    logic [DW-1:0] avg, hi01, hi23, hi, lo01, lo23, lo;
    always_comb begin
        sum  = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
        avg  = DW'(sum >> 2);
        hi01 = (p0 > p1) ? p0 : p1;
        hi23 = (p2 > p3) ? p2 : p3;
        hi   = (hi01 > hi23) ? hi01 : hi23;
        lo01 = (p0 < p1) ? p0 : p1;
        lo23 = (p2 < p3) ? p2 : p3;
        lo   = (lo01 < lo23) ? lo01 : lo23;
        {n0, n1, n2, n3} = {p0, p1, p2, p3};
        we = 1'b1;
        case (op)
            CMD_AVG:    {n0, n1, n2, n3} = {4{avg}};
            CMD_MIRX:   {n0, n1, n2, n3} = {p2, p3, p0, p1};
            CMD_MIRY:   {n0, n1, n2, n3} = {p1, p0, p3, p2};
            CMD_MAX:    {n0, n1, n2, n3} = {4{hi}};
            CMD_MIN:    {n0, n1, n2, n3} = {4{lo}};
            CMD_ROTCW:  {n0, n1, n2, n3} = {p2, p0, p3, p1};
            CMD_ROTCCW: {n0, n1, n2, n3} = {p1, p3, p0, p2};
            default:    we = 1'b0;
        endcase
    end
endmodule

// File: rtl/lcd_ctrl_param.sv
// lcd_ctrl_param: loads a W x H image from IROM, edits it through a 2x2 cursor window, streams it to IRB
module lcd_ctrl_param import lcd_pkg::*; #(
    parameter int DW = 8,
    parameter int XW = 3,
    parameter int YW = 3
) (
    input logic             clk,
    input logic             reset,
    lcd_ctrl_param_if.slave bus
);
    localparam int AW = XW + YW;
    localparam int N = 1 << AW;
    localparam logic [XW-1:0] X_HOME = XW'(1 << (XW - 1));
    localparam logic [YW-1:0] Y_HOME = YW'(1 << (YW - 1));
    localparam logic [AW-1:0] A_LAST = AW'(N - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic [3:0]    cmd_q, cmd_d;
    logic          irom_en_q, irom_en_d, irb_rw_q, irb_rw_d, busy_q, busy_d, done_q, done_d;
    logic [AW-1:0] irom_a_q, irom_a_d, irb_a_q, irb_a_d;
    logic [DW-1:0] irb_d_q, irb_d_d;
    logic [DW-1:0] pix [N];
    logic [AW-1:0] a0, a1, a2, a3;
    logic [DW-1:0] n0, n1, n2, n3;
    logic          we;

    // cursor is the bottom-right corner of the window
    assign a0 = AW'(pix_addr(int'(cy_q) - 1, int'(cx_q) - 1, XW));
    assign a1 = AW'(pix_addr(int'(cy_q) - 1, int'(cx_q), XW));
    assign a2 = AW'(pix_addr(int'(cy_q), int'(cx_q) - 1, XW));
    assign a3 = AW'(pix_addr(int'(cy_q), int'(cx_q), XW));

    lcd_window_alu #(.DW(DW)) u_alu (
        .op(cmd_q), .p0(pix[a0]), .p1(pix[a1]), .p2(pix[a2]), .p3(pix[a3]),
        .n0(n0), .n1(n1), .n2(n2), .n3(n3), .we(we)
    );

    always_comb begin
        state_d   = state_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        cmd_d     = cmd_q;
        irom_en_d = irom_en_q;
        irom_a_d  = irom_a_q;
        irb_rw_d  = irb_rw_q;
        irb_a_d   = irb_a_q;
        irb_d_d   = irb_d_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            S_LOAD: begin
                irom_a_d = (irom_a_q == A_LAST) ? irom_a_q : irom_a_q + 1'b1;
                if (irom_a_q == A_LAST) begin
                    irom_en_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_IDLE: if (bus.cmd_valid) begin
                cmd_d   = bus.cmd;
                busy_d  = 1'b1;
                state_d = (bus.cmd == CMD_WRITE) ? S_WRITE : S_EXEC;
                if (bus.cmd == CMD_WRITE) begin
                    irb_rw_d = 1'b0;
                    irb_a_d  = '0;
                    irb_d_d  = pix[0];
                end
            end
            S_EXEC: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
                cx_d = (cmd_q == CMD_LEFT && cx_q != XW'(1)) ? cx_q - 1'b1 :
                       (cmd_q == CMD_RIGHT && !(&cx_q))    ? cx_q + 1'b1 :
                       (cmd_q == CMD_HOME)                 ? X_HOME : cx_q;
                cy_d = (cmd_q == CMD_UP && cy_q != YW'(1)) ? cy_q - 1'b1 :
                       (cmd_q == CMD_DOWN && !(&cy_q))     ? cy_q + 1'b1 :
                       (cmd_q == CMD_HOME)                 ? Y_HOME : cy_q;
            end
            S_WRITE: begin
                irb_a_d = irb_a_q + 1'b1;
                irb_d_d = pix[irb_a_q + 1'b1];
                if (irb_a_q == A_LAST) begin
                    irb_a_d  = irb_a_q;
                    irb_d_d  = irb_d_q;
                    irb_rw_d = 1'b1;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q   <= S_LOAD;
            cx_q      <= X_HOME;
            cy_q      <= Y_HOME;
            cmd_q     <= CMD_WRITE;
            irom_en_q <= 1'b0;
            irom_a_q  <= '0;
            irb_rw_q  <= 1'b1;
            irb_a_q   <= '0;
            irb_d_q   <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            cmd_q     <= cmd_d;
            irom_en_q <= irom_en_d;
            irom_a_q  <= irom_a_d;
            irb_rw_q  <= irb_rw_d;
            irb_a_q   <= irb_a_d;
            irb_d_q   <= irb_d_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end

    // window writes all use pre-update reads, so swaps and rotations are simultaneous
    always_ff @(posedge clk) begin
        if (state_q == S_LOAD) pix[irom_a_q] <= bus.IROM_Q;
        if (state_q == S_EXEC && we) begin
            pix[a0] <= n0;
            pix[a1] <= n1;
            pix[a2] <= n2;
            pix[a3] <= n3;
        end
    end

    assign bus.IROM_EN = irom_en_q;
    assign bus.IROM_A  = irom_a_q;
    assign bus.IRB_RW  = irb_rw_q;
    assign bus.IRB_D   = irb_d_q;
    assign bus.IRB_A   = irb_a_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// tb_lcd_ctrl_param: directed vectors and hand sequences for the LCD controller at two parameter sets
module tb_lcd_ctrl_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int tests = 0;
    int fails = 0;
    logic [7:0] cap_a [64];
    logic [9:0] cap_b [128];

    lcd_ctrl_param_if #(.DW(8), .AW(6)) a_if ();
    lcd_ctrl_param_if #(.DW(10), .AW(7)) b_if ();
    lcd_ctrl_param dut_a (.clk(clk), .reset(reset), .bus(a_if));
    lcd_ctrl_param #(.DW(10), .XW(4), .YW(3)) dut_b (.clk(clk), .reset(reset), .bus(b_if));

    always #5 clk = ~clk;
    assign a_if.IROM_Q = {2'b00, a_if.IROM_A};
    assign b_if.IROM_Q = (b_if.IROM_A == 7'd55) ? 10'd1020 : 10'd1023;

    typedef struct packed {
        logic           reload;
        logic [3:0]     cmd;
        logic [2:0]     rep;
        logic [3:0]     cmd2;
        logic [3:0][5:0] addr;
        logic [3:0][7:0] val;
    } vec_t;
    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic rl, input logic [3:0] c, input logic [2:0] r, input logic [3:0] c2,
                                input logic [5:0] x0, x1, x2, x3, input logic [7:0] v0, v1, v2, v3);
        vec_t v;
        v.reload = rl;
        v.cmd    = c;
        v.rep    = r;
        v.cmd2   = c2;
        v.addr   = {x3, x2, x1, x0};
        v.val    = {v3, v2, v1, v0};
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_a(output int cyc);
        cyc = 0;
        while (a_if.busy && cyc < 300) begin @(posedge clk); #1; cyc++; end
        if (a_if.busy) begin tests++; fails++; $display("FAIL wait_a: busy=1 after %0d cycles, expected 0", cyc); end
    endtask

    task automatic wait_b(output int cyc);
        cyc = 0;
        while (b_if.busy && cyc < 300) begin @(posedge clk); #1; cyc++; end
        if (b_if.busy) begin tests++; fails++; $display("FAIL wait_b: busy=1 after %0d cycles, expected 0", cyc); end
    endtask

    task automatic issue_a(input logic [3:0] c);
        int cyc;
        wait_a(cyc);
        @(negedge clk);
        a_if.cmd = c;
        a_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1 a_if.cmd_valid = 1'b0;
    endtask

    task automatic issue_b(input logic [3:0] c);
        int cyc;
        wait_b(cyc);
        @(negedge clk);
        b_if.cmd = c;
        b_if.cmd_valid = 1'b1;
        @(posedge clk);
        #1 b_if.cmd_valid = 1'b0;
    endtask

    task automatic write_a(output int beats, output int order_err, output int dones);
        int n;
        issue_a(4'd0);
        beats = 0; order_err = 0; dones = 0; n = 0;
        while (dones == 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (!a_if.IRB_RW) begin
                if (int'(a_if.IRB_A) != beats) order_err++;
                cap_a[a_if.IRB_A] = a_if.IRB_D;
                beats++;
            end
            if (a_if.done) dones++;
        end
        if (dones == 0) begin tests++; fails++; $display("FAIL write_a: done=0 after %0d cycles, expected 1", n); end
    endtask

    task automatic write_b(output int beats, output int order_err, output int dones);
        int n;
        issue_b(4'd0);
        beats = 0; order_err = 0; dones = 0; n = 0;
        while (dones == 0 && n < 300) begin
            @(negedge clk);
            n++;
            if (!b_if.IRB_RW) begin
                if (int'(b_if.IRB_A) != beats) order_err++;
                cap_b[b_if.IRB_A] = b_if.IRB_D;
                beats++;
            end
            if (b_if.done) dones++;
        end
        if (dones == 0) begin tests++; fails++; $display("FAIL write_b: done=0 after %0d cycles, expected 1", n); end
    endtask

    initial begin
        int cyc, beats, oerr, dones, diff;
        logic [3:0] bpat;
        logic [7:0] prev [64];
        a_if.cmd = '0; a_if.cmd_valid = 1'b0;
        b_if.cmd = '0; b_if.cmd_valid = 1'b0;
        // centre window at (4,4) on the ramp: p0=27 p1=28 p2=35 p3=36
        vecs[0]  = mk(1, 5, 1, 15, 27, 28, 35, 36, 31, 31, 31, 31);
        vecs[1]  = mk(1, 8, 1, 15, 27, 28, 35, 36, 36, 36, 36, 36);
        vecs[2]  = mk(1, 9, 1, 15, 27, 28, 35, 36, 27, 27, 27, 27);
        vecs[3]  = mk(1, 10, 1, 15, 27, 28, 35, 36, 35, 27, 36, 28);
        vecs[4]  = mk(0, 11, 1, 15, 27, 28, 35, 36, 27, 28, 35, 36);
        vecs[5]  = mk(1, 6, 1, 15, 27, 28, 35, 36, 35, 36, 27, 28);
        vecs[6]  = mk(1, 7, 1, 15, 27, 28, 35, 36, 28, 27, 36, 35);
        vecs[7]  = mk(1, 1, 5, 6, 3, 4, 11, 12, 11, 12, 3, 4);
        vecs[8]  = mk(0, 12, 1, 6, 27, 28, 35, 36, 35, 36, 27, 28);
        vecs[9]  = mk(1, 3, 5, 7, 24, 25, 32, 33, 25, 24, 33, 32);
        vecs[10] = mk(1, 4, 5, 7, 30, 31, 38, 39, 31, 30, 39, 38);
        vecs[11] = mk(1, 2, 5, 7, 51, 52, 59, 60, 52, 51, 60, 59);
        vecs[12] = mk(1, 14, 1, 15, 27, 28, 35, 36, 27, 28, 35, 36);
        vecs[13] = mk(1, 13, 1, 5, 27, 28, 35, 36, 31, 31, 31, 31);

        #12;
        check("rst_busy", a_if.busy, 1);
        check("rst_done", a_if.done, 0);
        check("rst_irom_en", a_if.IROM_EN, 0);
        check("rst_irom_a", a_if.IROM_A, 0);
        check("rst_irb_rw", a_if.IRB_RW, 1);
        check("rst_irb_d", a_if.IRB_D, 0);
        check("rst_irb_a", a_if.IRB_A, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_a(cyc);
        check("load_cycles", cyc, 64);
        check("load_irom_en", a_if.IROM_EN, 1);
        check("load_irom_a_hold", a_if.IROM_A, 63);

        write_a(beats, oerr, dones);
        check("ramp_beats", beats, 64);
        check("ramp_order", oerr, 0);
        diff = 0;
        for (int k = 0; k < 64; k++) if (int'(cap_a[k]) != k) diff++;
        check("ramp_data", diff, 0);
        check("done_busy", a_if.busy, 0);
        check("done_rw", a_if.IRB_RW, 1);
        @(negedge clk);
        check("done_width", a_if.done, 0);

        for (int i = 0; i < NV; i++) begin
            if (vecs[i].reload) begin do_reset(); wait_a(cyc); end
            for (int r = 0; r < int'(vecs[i].rep); r++) issue_a(vecs[i].cmd);
            issue_a(vecs[i].cmd2);
            write_a(beats, oerr, dones);
            for (int k = 0; k < 4; k++)
                check($sformatf("vec%0d_pix%0d", i, vecs[i].addr[k]), cap_a[vecs[i].addr[k]], vecs[i].val[k]);
        end

        // cmd_valid held across EXEC: only the idle-cycle samples count, y moves 4 -> 6
        do_reset();
        wait_a(cyc);
        @(negedge clk);
        a_if.cmd = 4'd2;
        a_if.cmd_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin @(posedge clk); #1; bpat[3-k] = a_if.busy; end
        a_if.cmd_valid = 1'b0;
        check("held_busy_pattern", bpat, 4'b1010);
        issue_a(4'd7);
        write_a(beats, oerr, dones);
        check("held_pix43", cap_a[43], 44);
        check("held_pix44", cap_a[44], 43);
        check("held_pix51", cap_a[51], 52);
        check("held_pix52", cap_a[52], 51);

        for (int k = 0; k < 64; k++) prev[k] = cap_a[k];
        issue_a(4'd14);
        check("rsv_busy_hi", a_if.busy, 1);
        @(posedge clk);
        #1 check("rsv_busy_lo", a_if.busy, 0);
        write_a(beats, oerr, dones);
        diff = 0;
        for (int k = 0; k < 64; k++) if (cap_a[k] != prev[k]) diff++;
        check("rsv_image", diff, 0);

        issue_a(4'd0);
        repeat (10) @(negedge clk);
        check("mid_write_rw", a_if.IRB_RW, 0);
        #2 reset = 1'b1;
        #1;
        check("abort_rw", a_if.IRB_RW, 1);
        check("abort_busy", a_if.busy, 1);
        check("abort_irom_en", a_if.IROM_EN, 0);
        @(negedge clk);
        reset = 1'b0;
        wait_a(cyc);
        check("reload_cycles", cyc, 64);
        write_a(beats, oerr, dones);
        check("reload_beats", beats, 64);
        diff = 0;
        for (int k = 0; k < 64; k++) if (int'(cap_a[k]) != k) diff++;
        check("reload_data", diff, 0);

        do_reset();
        wait_b(cyc);
        check("b_load_cycles", cyc, 128);
        issue_b(4'd5);
        write_b(beats, oerr, dones);
        check("b_beats", beats, 128);
        check("b_order", oerr, 0);
        check("b_done", dones, 1);
        check("b_pix55", cap_b[55], 1022);
        check("b_pix56", cap_b[56], 1022);
        check("b_pix71", cap_b[71], 1022);
        check("b_pix72", cap_b[72], 1022);
        check("b_pix54", cap_b[54], 1023);
        check("b_pix127", cap_b[127], 1023);
        @(negedge clk);
        check("b_done_width", b_if.done, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
